// File: rtl/common_types_pkg.sv
// Shared types for the core/memory slice: RAM handshake states, prefetch FSM
// states, the buffered fetch entry and a saturating add for event counters.
package common_types_pkg;

  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_BUSY = 2'd1,
    RAM_DONE = 2'd2
  } ram_state_t;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_BUSY    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/ram_if.sv
// Word-wide RAM request/response bundle; the core side initiates, the RAM
// answers with RAM_DONE and a load word valid in that cycle only.
interface ram_if;
  import common_types_pkg::*;

  logic        ren;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] store;
  logic [31:0] load;
  ram_state_t  state;

  modport cpu (output ren, wen, addr, store, input load, state);
  modport ram (input ren, wen, addr, store, output load, state);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH x 64-bit FIFO holding {pc, word} pairs; clear empties it
// in one cycle and wins over a same-cycle push or pop.
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage has no reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: sequential word reads into a small FIFO, flushed and
// restarted on redirect. Define FETCH_PERF_EN to add fetched/discarded counters.
module fetch_prefetch
  import common_types_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  ram_if.cpu          ram,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   fpc, fpc_nxt, req_addr, req_addr_nxt, new_pc;
  logic          done, push, pop, full, empty;
  logic [CW-1:0] count, count_after;
  logic [63:0]   head_raw;
  fetch_entry_t  head, wentry;

  assign new_pc      = redirect_pc & ~32'h3;
  assign done        = (ram.state == RAM_DONE);
  assign push        = (state == FETCH_BUSY) && done && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign count_after = count + CW'(1) - CW'(pop);

  // Request address lives in req_addr so a redirect can move fpc while the
  // outstanding access keeps its address until DONE.
  assign ram.ren   = (state != FETCH_IDLE);
  assign ram.wen   = 4'b0;
  assign ram.store = 32'b0;
  assign ram.addr  = req_addr;

  // NOTE: defaults first so every path assigns each signal and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    fpc_nxt      = fpc;
    req_addr_nxt = req_addr;
    case (state)
      FETCH_IDLE: begin
        if (redirect) begin
          fpc_nxt = new_pc;
        end else if (!full) begin
          state_nxt    = FETCH_BUSY;
          req_addr_nxt = fpc;
        end
      end
      FETCH_BUSY: begin
        if (redirect) begin
          fpc_nxt   = new_pc;
          state_nxt = done ? FETCH_IDLE : FETCH_DISCARD;
        end else if (done) begin
          fpc_nxt = fpc + 32'd4;
          if (count_after < CW'(DEPTH)) req_addr_nxt = fpc + 32'd4;
          else                          state_nxt    = FETCH_IDLE;
        end
      end
      FETCH_DISCARD: begin
        if (redirect) fpc_nxt = new_pc;
        if (done)     state_nxt = FETCH_IDLE;
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= FETCH_IDLE;
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fpc      <= fpc_nxt;
      req_addr <= req_addr_nxt;
    end
  end

  assign wentry = '{pc: fpc, word: ram.load};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata (wentry),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head        = fetch_entry_t'(head_raw);
  assign instr_valid = !empty;
  assign instr       = instr_valid ? head.word : 32'b0;
  assign instr_pc    = instr_valid ? head.pc   : 32'b0;

`ifdef FETCH_PERF_EN
  logic [31:0] drop_cnt;

  // A redirect drops every buffered entry plus the word still owed by BUSY;
  // a DISCARD access was already counted when it was abandoned.
  assign drop_cnt = 32'(count) + ((state == FETCH_BUSY) ? 32'd1 : 32'd0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (push)     perf_fetched   <= sat_add32(perf_fetched, 32'd1);
      if (redirect) perf_discarded <= sat_add32(perf_discarded, drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: behavioural RAM responder with variable latency,
// a queue of expected {pc, word} entries, a redirect vector table and corner sequences.
module tb_fetch_prefetch;
  import common_types_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded;
`endif

  ram_if bus ();

  fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .ram         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC0DE};
  endfunction

  // RAM responder: DONE lat+1 cycles after ren is first seen, restart after DONE.
  int          lat = 0;
  int          rcnt;
  int          done_cnt;
  ram_state_t  rstate;
  logic [31:0] req_latch;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rstate    <= RAM_IDLE;
      rcnt      <= 0;
      done_cnt  <= 0;
      req_latch <= '0;
    end else if (rstate == RAM_DONE) begin
      rstate   <= RAM_IDLE;
      rcnt     <= 0;
      done_cnt <= done_cnt + 1;
    end else if (bus.ren) begin
      if (rstate == RAM_IDLE) req_latch <= bus.addr;
      if (rcnt >= lat) begin
        rstate <= RAM_DONE;
      end else begin
        rstate <= RAM_BUSY;
        rcnt   <= rcnt + 1;
      end
    end
  end

  assign bus.state = rstate;
  assign bus.load  = (rstate == RAM_DONE) ? mem_word(bus.addr) : 32'hDEAD_DEAD;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];

  task automatic sb_load(input logic [31:0] pc, input int n);
    logic [31:0] p;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      p = pc + 32'(4 * i);
      sb.push_back('{pc: p, word: mem_word(p)});
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Inputs set here are sampled at the next posedge; the accept decision uses them.
  task automatic drive(input logic r, input logic red, input logic [31:0] rpc);
    exp_t e;
    instr_ready = r;
    redirect    = red;
    redirect_pc = rpc;
    if (bus.state == RAM_DONE) check("addr_hold", bus.addr, req_latch);
    if (red) begin
      sb.delete();
    end else if (instr_valid && r) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h want none", instr_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_word", instr, e.word);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic red, input logic [31:0] rpc);
    tick();
    drive(r, red, rpc);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() > 0 && k < 200) begin
      cyc(1'b1, 1'b0, 32'h0);
      k++;
    end
    check(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_reset(input int new_lat);
    instr_ready = 1'b0;
    redirect    = 1'b0;
    nrst        = 1'b0;
    lat         = new_lat;
    sb.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  typedef struct {
    int          lat;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    int          n;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit found;

    vecs[0] = '{lat: 0, rpc: 32'h0000_1000, exp_pc: 32'h0000_1000, n: 4};
    vecs[1] = '{lat: 1, rpc: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC, n: 3};
    vecs[2] = '{lat: 2, rpc: 32'h0000_0ABE, exp_pc: 32'h0000_0ABC, n: 3};
    vecs[3] = '{lat: 3, rpc: 32'h8000_0001, exp_pc: 32'h8000_0000, n: 2};

    // Reset state.
    lat = 0;
    repeat (3) @(negedge clk);
    check("rst_ren", 32'(bus.ren), 32'd0);
    check("rst_wen", 32'(bus.wen), 32'd0);
    check("rst_addr", bus.addr, RST_PC);
    check("rst_store", bus.store, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_discarded", perf_discarded, 32'd0);
`endif

    // Streaming from reset, LAT=0: one word every 2 cycles.
    sb_load(RST_PC, 8);
    instr_ready = 1'b1;
    nrst        = 1'b1;
    tick();
    check("t1_c0_ren", 32'(bus.ren), 32'd1);
    check("t1_c0_addr", bus.addr, RST_PC);
    check("t1_c0_valid", 32'(instr_valid), 32'd0);
    drive(1'b1, 1'b0, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("t1_ren", 32'(bus.ren), 32'd1);
      check("t1_valid", 32'(instr_valid), 32'((c % 2) == 0));
      check("t1_addr", bus.addr, RST_PC + 32'(4 * (c / 2)));
      drive(1'b1, 1'b0, 32'h0);
    end
    drain("t1_drain");

    // Backpressure: exactly DEPTH reads, then one more after a single pop.
    do_reset(0);
    sb_load(RST_PC, 5);
    repeat (30) cyc(1'b0, 1'b0, 32'h0);
    check("t2_reads_full", 32'(done_cnt), 32'd4);
    check("t2_ren_full", 32'(bus.ren), 32'd0);
    check("t2_valid_full", 32'(instr_valid), 32'd1);
    cyc(1'b1, 1'b0, 32'h0);
    repeat (20) cyc(1'b0, 1'b0, 32'h0);
    check("t2_reads_one_more", 32'(done_cnt), 32'd5);
    check("t2_ren_refull", 32'(bus.ren), 32'd0);
    drain("t2_drain");

    // LAT=2, redirect one cycle after ren rises: old access completes and is dropped.
    do_reset(2);
    tick();
    check("t3_c0_ren", 32'(bus.ren), 32'd1);
    check("t3_c0_addr", bus.addr, RST_PC);
    drive(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_2003);
    sb_load(32'h0000_2000, 3);
    tick();
    check("t3_c2_ren", 32'(bus.ren), 32'd1);
    check("t3_c2_addr", bus.addr, RST_PC);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check("t3_c3_done", 32'(bus.state == RAM_DONE), 32'd1);
    check("t3_c3_addr", bus.addr, RST_PC);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check("t3_c4_ren", 32'(bus.ren), 32'd0);
    check("t3_c4_valid", 32'(instr_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check("t3_c5_ren", 32'(bus.ren), 32'd1);
    check("t3_c5_addr", bus.addr, 32'h0000_2000);
    drive(1'b0, 1'b0, 32'h0);
    drain("t3_drain");

    // Redirect in a DONE cycle while the head is being popped.
    lat = 0;
    cyc(1'b0, 1'b1, 32'h0000_4000);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      if (bus.state == RAM_DONE && instr_valid) found = 1'b1;
      else drive(1'b0, 1'b0, 32'h0);
    end
    check("t4_found_done", 32'(found), 32'd1);
    if (!found) tick();
    drive(1'b1, 1'b1, 32'h0000_5000);
    sb_load(32'h0000_5000, 2);
    tick();
    check("t4_valid_cleared", 32'(instr_valid), 32'd0);
    check("t4_ren_idle", 32'(bus.ren), 32'd0);
    drive(1'b0, 1'b0, 32'h0);
    drain("t4_drain");

    // Redirect vectors, including PC wrap and low-bit masking.
    foreach (vecs[i]) begin
      lat = vecs[i].lat;
      cyc(1'b0, 1'b1, vecs[i].rpc);
      sb_load(vecs[i].exp_pc, vecs[i].n);
      drain($sformatf("vec%0d_drain", i));
    end

`ifdef FETCH_PERF_EN
    // Three buffered words plus one in flight, then redirect.
    do_reset(3);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (done_cnt == 3 && bus.ren && bus.state != RAM_DONE) found = 1'b1;
      else drive(1'b0, 1'b0, 32'h0);
    end
    check("perf_found", 32'(found), 32'd1);
    if (!found) tick();
    drive(1'b0, 1'b1, 32'h0000_6000);
    tick();
    check("perf_fetched", perf_fetched, 32'd3);
    check("perf_discarded", perf_discarded, 32'd4);
    drive(1'b0, 1'b0, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
